// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and chunk geometry helpers for the vector write-back collector
package vec_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    localparam int IDX_W       = 10;
    localparam int LANE_DATA_W = 64;

    function automatic int chunk_count(input int vlen, input int lane_width);
        return vlen >> lane_width;
    endfunction

    // Chunk must start on a chunk boundary and lie inside the register.
    function automatic logic idx_legal(input logic [IDX_W-1:0] idx, input int vlen,
                                       input int lane_width);
        logic [IDX_W-1:0] mask;
        mask = (IDX_W'(1) << lane_width) - IDX_W'(1);
        return ((idx & mask) == '0) && (int'(idx) < vlen);
    endfunction

endpackage

// File: rtl/vec_chunk_arbiter.sv
// rtl/vec_chunk_arbiter.sv - per-chunk lowest-lane select with duplicate and collision detection
module vec_chunk_arbiter
    import vec_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4,
    parameter int NB_LANES   = 4,
    parameter int CHUNKS     = chunk_count(VLEN, LANE_WIDTH)
) (
    input  logic [NB_LANES-1:0]             in_valid,
    input  logic [NB_LANES*IDX_W-1:0]       in_index,
    input  logic [NB_LANES*LANE_DATA_W-1:0] in_data,
    input  logic [CHUNKS-1:0]               covered,
    output logic [CHUNKS-1:0]               we,
    output logic [VLEN-1:0]                 chunk_data,
    output logic                            conflict
);

    localparam int CW  = 1 << LANE_WIDTH;
    localparam int CIW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [NB_LANES-1:0] lane_legal;
    logic [CIW-1:0]      lane_chunk [NB_LANES];

    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
        assign lane_legal[l] = idx_legal(in_index[l*IDX_W +: IDX_W], VLEN, LANE_WIDTH);
        assign lane_chunk[l] = in_index[l*IDX_W + LANE_WIDTH +: CIW];
    end

    // Lanes carry up to 64 bits; only the low chunk-width bits are consumed.
    logic unused_data;
    assign unused_data = ^in_data;

    // Lanes are walked in ascending order so the lowest lane claims a chunk first.
    always_comb begin
        we         = '0;
        chunk_data = '0;
        conflict   = 1'b0;
        for (int l = 0; l < NB_LANES; l++) begin
            if (in_valid[l] && !lane_legal[l]) begin
                conflict = 1'b1;
            end
            for (int c = 0; c < CHUNKS; c++) begin
                if (in_valid[l] && lane_legal[l] && lane_chunk[l] == CIW'(c)) begin
                    if (covered[c] || we[c]) begin
                        conflict = 1'b1;
                    end else begin
                        we[c]                  = 1'b1;
                        chunk_data[c*CW +: CW] = in_data[l*LANE_DATA_W +: CW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vec_wb_collector.sv
// rtl/vec_wb_collector.sv - assembles lane result chunks into one vector register write
module vec_wb_collector
    import vec_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4,
    parameter int NB_LANES   = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [4:0]                      vd_addr,
    input  logic [NB_LANES-1:0]             in_valid,
    input  logic [NB_LANES*LANE_DATA_W-1:0] in_data,
    input  logic [NB_LANES*IDX_W-1:0]       in_index,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [4:0]                      wr_addr,
    output logic [VLEN-1:0]                 wr_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int CHUNKS = chunk_count(VLEN, LANE_WIDTH);
    localparam int CW     = 1 << LANE_WIDTH;

    state_t            state;
    logic [CHUNKS-1:0] bitmap;
    logic [CHUNKS-1:0] we;
    logic [VLEN-1:0]   chunk_data;
    logic              conflict;

    vec_chunk_arbiter #(
        .VLEN       (VLEN),
        .LANE_WIDTH (LANE_WIDTH),
        .NB_LANES   (NB_LANES),
        .CHUNKS     (CHUNKS)
    ) u_arb (
        .in_valid   (in_valid),
        .in_index   (in_index),
        .in_data    (in_data),
        .covered    (bitmap),
        .we         (we),
        .chunk_data (chunk_data),
        .conflict   (conflict)
    );

    // wr_data doubles as the assembly buffer so it is stable once WRITE is reached.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            bitmap   <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_addr <= vd_addr;
                        wr_data <= '0;
                        bitmap  <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (conflict) begin
                        err <= 1'b1;
                    end
                    for (int c = 0; c < CHUNKS; c++) begin
                        if (we[c]) begin
                            wr_data[c*CW +: CW] <= chunk_data[c*CW +: CW];
                        end
                    end
                    bitmap <= bitmap | we;
                    if (&(bitmap | we)) begin
                        wr_valid <= 1'b1;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (|in_valid) begin
                        err <= 1'b1;
                    end
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wr_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_wb_collector.sv
// tb/tb_vec_wb_collector.sv - scoreboard bench for the vector write-back collector
module tb_vec_wb_collector;

    localparam int VLEN = 128;
    localparam int LW   = 4;
    localparam int NBL  = 2;

    localparam logic [127:0] D1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [127:0] D2 = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
    localparam logic [127:0] D3 = 128'h8888_7777_6666_5555_4444_AAAA_2222_1111;

    typedef struct packed {
        logic [4:0]   addr;
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [4:0]       vd_addr;
    logic [NBL-1:0]   in_valid;
    logic [NBL*64-1:0] in_data;
    logic [NBL*10-1:0] in_index;
    logic             wr_valid;
    logic             wr_ready;
    logic [4:0]       wr_addr;
    logic [VLEN-1:0]  wr_data;
    logic             busy;
    logic             done;
    logic             err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    vec_wb_collector #(
        .VLEN       (VLEN),
        .LANE_WIDTH (LW),
        .NB_LANES   (NBL)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .vd_addr  (vd_addr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_index (in_index),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [9:0] i0, input logic [15:0] d0,
                         input logic [9:0] i1, input logic [15:0] d1, input logic [1:0] v);
        in_valid = v;
        in_index = {i1, i0};
        in_data  = {48'h0, d1, 48'h0, d0};
        step();
        in_valid = '0;
    endtask

    task automatic fill_pair(input logic [127:0] v, input int k);
        send2(10'(32*k), v[32*k +: 16], 10'(32*k + 16), v[32*k + 16 +: 16], 2'b11);
    endtask

    task automatic fill(input logic [127:0] v);
        for (int k = 0; k < 4; k++) fill_pair(v, k);
    endtask

    task automatic do_start(input logic [4:0] a);
        start   = 1'b1;
        vd_addr = a;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            step();
        end
        chk("done_seen", done, 1);
    endtask

    // Monitor: pops the scoreboard on every handshake, then expects the done pulse.
    initial begin
        bit   prev_hs;
        exp_t e;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_hs) begin
                chk("done_pulse", done, 1);
                chk("busy_after_done", busy, 0);
            end else if (done) begin
                chk("spurious_done", done, 0);
            end
            prev_hs = wr_valid && wr_ready;
            if (prev_hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("err_at_write", err, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        vd_addr  = '0;
        in_valid = '0;
        in_data  = '0;
        in_index = '0;
        wr_ready = 1'b1;
        step();
        step();
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        resetn = 1'b1;
        step();

        // Basic fill with ready already high
        exp_q.push_back('{addr: 5'd5, data: D1, err: 1'b0});
        do_start(5'd5);
        chk("busy_collect", busy, 1);
        fill(D1);
        chk("wr_valid_latency", wr_valid, 1);
        wait_done();
        step();

        // Back-pressure: held stable while wr_ready is low
        wr_ready = 1'b0;
        exp_q.push_back('{addr: 5'd9, data: D2, err: 1'b0});
        do_start(5'd9);
        fill(D2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_wr_valid", wr_valid, 1);
            chk("bp_wr_data", wr_data, D2);
            chk("bp_done", done, 0);
            step();
        end
        wr_ready = 1'b1;
        wait_done();
        step();

        // Same-cycle collision on chunk 2: lane 0 wins
        exp_q.push_back('{addr: 5'd3, data: D3, err: 1'b1});
        do_start(5'd3);
        send2(10'd32, 16'hAAAA, 10'd32, 16'hBBBB, 2'b11);
        chk("collision_err", err, 1);
        send2(10'd0, 16'h1111, 10'd16, 16'h2222, 2'b11);
        send2(10'd48, 16'h4444, 10'd64, 16'h5555, 2'b11);
        send2(10'd80, 16'h6666, 10'd96, 16'h7777, 2'b11);
        chk("collision_no_wr_yet", wr_valid, 0);
        send2(10'd112, 16'h8888, 10'd0, 16'h0000, 2'b01);
        wait_done();
        step();

        // Misaligned and out-of-range indices are dropped
        exp_q.push_back('{addr: 5'd7, data: D1, err: 1'b1});
        do_start(5'd7);
        send2(10'd24, 16'hDEAD, 10'd128, 16'hBEEF, 2'b11);
        chk("illegal_err", err, 1);
        chk("illegal_no_wr", wr_valid, 0);
        for (int k = 0; k < 3; k++) fill_pair(D1, k);
        chk("partial_no_wr", wr_valid, 0);
        fill_pair(D1, 3);
        chk("illegal_then_full_wr", wr_valid, 1);
        wait_done();
        step();

        // Reset mid-collection discards partial buffer
        do_start(5'd11);
        send2(10'd0, 16'hF0F0, 10'd16, 16'hF0F0, 2'b11);
        send2(10'd32, 16'hF0F0, 10'd48, 16'hF0F0, 2'b11);
        send2(10'd64, 16'hF0F0, 10'd0, 16'h0000, 2'b01);
        resetn = 1'b0;
        #1;
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_valid", wr_valid, 0);
        step();
        resetn = 1'b1;
        step();
        exp_q.push_back('{addr: 5'd12, data: D2, err: 1'b0});
        do_start(5'd12);
        fill(D2);
        wait_done();
        step();

        // start during WRITE ignored; start in done cycle accepted with err cleared
        wr_ready = 1'b0;
        exp_q.push_back('{addr: 5'd13, data: D1, err: 1'b1});
        do_start(5'd13);
        fill(D1);
        do_start(5'd20);
        chk("write_start_addr", wr_addr, 13);
        chk("write_start_err", err, 0);
        chk("write_start_valid", wr_valid, 1);
        send2(10'd0, 16'h5A5A, 10'd0, 16'h0000, 2'b01);
        chk("write_chunk_err", err, 1);
        chk("write_chunk_data", wr_data, D1);
        wr_ready = 1'b1;
        step();
        chk("done_cycle", done, 1);
        exp_q.push_back('{addr: 5'd21, data: D2, err: 1'b0});
        do_start(5'd21);
        chk("restart_busy", busy, 1);
        chk("restart_err_clear", err, 0);
        chk("restart_addr", wr_addr, 21);
        fill(D2);
        wait_done();
        step();
        step();

        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
